// File: rtl/stim_pwm_gen.sv
// stim_pwm_gen: multi-channel runtime-configurable PWM/level stimulus source.
// Define STIM_PRBS_EN to turn mode 2 into a per-channel PRBS7; otherwise mode 2 holds low.
module stim_pwm_gen #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 16,
   parameter int LVL_W = 16,
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic [CNT_W-1:0]        cfg_period,
   input  logic [CNT_W-1:0]        cfg_high,
   input  logic [1:0]              cfg_mode,
   input  logic signed [LVL_W-1:0] cfg_lvl_hi,
   input  logic signed [LVL_W-1:0] cfg_lvl_lo,
   input  logic [N_CH-1:0]         en,
   output logic [N_CH-1:0]         out_dig,
   output logic [N_CH*LVL_W-1:0]   out_lvl,
   output logic [N_CH-1:0]         wrap
);
   typedef struct packed {
      logic [CNT_W-1:0] p;
      logic [CNT_W-1:0] h;
      logic [1:0]       mode;
      logic [LVL_W-1:0] hi;
      logic [LVL_W-1:0] lo;
   } cfg_t;
   cfg_t            cfg_in;
   logic [N_CH-1:0] pend;
   assign cfg_in    = '{p: cfg_period, h: cfg_high, mode: cfg_mode, hi: cfg_lvl_hi, lo: cfg_lvl_lo};
   // Out-of-range channel numbers are never accepted.
   assign cfg_ready = (int'(cfg_ch) < N_CH) && !pend[cfg_ch];
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      cfg_t             act, shd;
      logic [CNT_W-1:0] cnt;
      logic             run, last, acc, prbs, dig_n, dig, wr;
      logic [LVL_W-1:0] lvl;
`ifdef STIM_PRBS_EN
      logic [6:0] lfsr;
      // x^7+x^6+1, advanced on the wrap edge so the bit is constant over each period.
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) lfsr <= 7'h7F;
         else if (!run) lfsr <= 7'h7F;
         else if (last) lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      assign prbs = lfsr[0];
`else
      assign prbs = 1'b0;
`endif
      always_comb begin
         run   = en[c] && act.p != '0;
         last  = cnt == act.p - CNT_W'(1);
         acc   = cfg_valid && cfg_ready && cfg_ch == CH_W'(c);
         dig_n = act.mode == 2'd0 ? cnt < act.h :
                 act.mode == 2'd1 ? cnt >= act.h :
                 act.mode == 2'd2 ? prbs : 1'b0;
      end
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            act     <= '0;
            shd     <= '0;
            pend[c] <= 1'b0;
            cnt     <= '0;
            dig     <= 1'b0;
            wr      <= 1'b0;
            lvl     <= '0;
         end else begin
            if (acc) begin
               shd     <= cfg_in;
               pend[c] <= 1'b1;
            end else if (pend[c] && (!run || last)) begin
               act     <= shd;
               pend[c] <= 1'b0;
            end
            cnt <= (!run || last) ? '0 : cnt + CNT_W'(1);
            wr  <= run && last;
            dig <= run && dig_n;
            lvl <= (run && dig_n) ? act.hi : act.lo;
         end
      assign out_dig[c]                 = dig;
      assign wrap[c]                    = wr;
      assign out_lvl[c*LVL_W +: LVL_W] = lvl;
   end
endmodule
